// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the two-digit BCD stopwatch: state encoding,
// digit limits and the frozen-display payload.
package stopwatch_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned PRESC_W = 16;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_pair_t;

endpackage

// File: rtl/bcd_digit.sv
// One decimal counter digit: wraps 9 -> 0 and flags the carry to the next digit.
module bcd_digit
  import stopwatch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  // Any out-of-range value is folded back to 0 on the next increment.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = (q_q >= BCD_MAX) ? '0 : q_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = en && (q_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/pause/resume FSM, tick prescaler, 00..99 BCD
// count and a lap-hold register that can freeze the displayed value.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               lap,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] disp_ones,
  output logic [DIGIT_W-1:0] disp_tens,
  output logic               running,
  output logic               lap_hold,
  output logic               wrap
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               lap_hold_q, lap_hold_d;
  bcd_pair_t          freeze_q, freeze_d;
  logic               wrap_q, wrap_d;

  logic tick;
  logic ones_en;
  logic ones_carry;
  logic tens_carry;

  assign tick    = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign ones_en = tick && !clear;

  bcd_digit u_ones (
    .clk   (clk),
    .rst   (rst),
    .en    (ones_en),
    .clr   (clear),
    .q     (ones),
    .carry (ones_carry)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .rst   (rst),
    .en    (ones_carry),
    .clr   (clear),
    .q     (tens),
    .carry (tens_carry)
  );

  // Next-state, prescaler and lap logic; clear overrides every other command.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    lap_hold_d = lap_hold_q;
    freeze_d   = freeze_q;
    wrap_d     = 1'b0;

    if (clear) begin
      state_d    = IDLE;
      presc_d    = '0;
      lap_hold_d = 1'b0;
      freeze_d   = '0;
    end else begin
      wrap_d = tens_carry;

      case (state_q)
        RUN:     presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        PAUSE:   presc_d = presc_q;
        default: presc_d = '0;
      endcase

      if (start_stop) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = IDLE;
        endcase
      end

      // Capture uses the pre-increment digits, even on a tick cycle.
      if (lap && (state_q != IDLE)) begin
        if (!lap_hold_q) begin
          freeze_d   = '{tens: tens, ones: ones};
          lap_hold_d = 1'b1;
        end else begin
          lap_hold_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      lap_hold_q <= 1'b0;
      freeze_q   <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      lap_hold_q <= lap_hold_d;
      freeze_q   <= freeze_d;
      wrap_q     <= wrap_d;
    end
  end

  assign running   = (state_q == RUN);
  assign lap_hold  = lap_hold_q;
  assign wrap      = wrap_q;
  assign disp_ones = lap_hold_q ? freeze_q.ones : ones;
  assign disp_tens = lap_hold_q ? freeze_q.tens : tens;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a decimal-count reference model queues
// the expected outputs per edge; a monitor compares them after each edge.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] disp_ones;
  logic [3:0] disp_tens;
  logic       running;
  logic       lap_hold;
  logic       wrap;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .ones       (ones),
    .tens       (tens),
    .disp_ones  (disp_ones),
    .disp_tens  (disp_tens),
    .running    (running),
    .lap_hold   (lap_hold),
    .wrap       (wrap)
  );

  typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_e;

  typedef struct {
    int ones;
    int tens;
    int dones;
    int dtens;
    int running;
    int hold;
    int wrap;
  } exp_t;

  exp_t exp_q[$];

  mstate_e m_st;
  int      m_cnt;
  int      m_presc;
  int      m_frz;
  bit      m_hold;
  bit      m_wrap;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input int expv);
    checks++;
    if (act !== 32'(expv)) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_st    = M_IDLE;
    m_cnt   = 0;
    m_presc = 0;
    m_frz   = 0;
    m_hold  = 1'b0;
    m_wrap  = 1'b0;
  endfunction

  // Effect of one rising edge given the commands sampled at that edge.
  function automatic void model_step(input bit ss, input bit cl, input bit lp);
    bit tick;
    tick   = (m_st == M_RUN) && (m_presc == DIV - 1);
    m_wrap = 1'b0;
    if (cl) begin
      model_reset();
      return;
    end
    if (lp && m_st != M_IDLE) begin
      if (!m_hold) begin
        m_frz  = m_cnt;
        m_hold = 1'b1;
      end else begin
        m_hold = 1'b0;
      end
    end
    if (tick) begin
      m_wrap = (m_cnt == 99);
      m_cnt  = (m_cnt + 1) % 100;
    end
    if (m_st == M_RUN)       m_presc = tick ? 0 : m_presc + 1;
    else if (m_st == M_IDLE) m_presc = 0;
    if (ss) m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   shown;
    shown     = m_hold ? m_frz : m_cnt;
    e.ones    = m_cnt % 10;
    e.tens    = m_cnt / 10;
    e.dones   = shown % 10;
    e.dtens   = shown / 10;
    e.running = (m_st == M_RUN) ? 1 : 0;
    e.hold    = m_hold ? 1 : 0;
    e.wrap    = m_wrap ? 1 : 0;
    return e;
  endfunction

  task automatic cycle(input bit ss, input bit cl, input bit lp);
    @(negedge clk);
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    model_step(ss, cl, lp);
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic run_until(input int target);
    int i;
    for (i = 0; i < 2000 && m_cnt != target; i++) cycle(1'b0, 1'b0, 1'b0);
    if (m_cnt != target) begin
      checks++;
      errors++;
      $display("FAIL run_until_%0d timed out", target);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ones"}, ones, 0);
    chk({tag, "_tens"}, tens, 0);
    chk({tag, "_disp_ones"}, disp_ones, 0);
    chk({tag, "_disp_tens"}, disp_tens, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_lap_hold"}, lap_hold, 0);
    chk({tag, "_wrap"}, wrap, 0);
  endtask

  // Monitor: pops one expectation per edge that had one queued.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_ones", ones, e.ones);
      chk("sb_tens", tens, e.tens);
      chk("sb_disp_ones", disp_ones, e.dones);
      chk("sb_disp_tens", disp_tens, e.dtens);
      chk("sb_running", running, e.running);
      chk("sb_lap_hold", lap_hold, e.hold);
      chk("sb_wrap", wrap, e.wrap);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    model_reset();
    #3;
    chk_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run(2);

    // Start, then first two ticks land DIV and 2*DIV edges later.
    cycle(1'b1, 1'b0, 1'b0);
    settle();
    chk("start_running", running, 1);
    run(4);
    settle();
    chk("first_tick_ones", ones, 1);
    run(4);
    settle();
    chk("second_tick_ones", ones, 2);

    // Remaining 98 ticks: rollover to 00 with a one-cycle wrap.
    run(98 * 4);
    settle();
    chk("rollover_ones", ones, 0);
    chk("rollover_tens", tens, 0);
    chk("rollover_wrap", wrap, 1);
    run(1);
    settle();
    chk("wrap_drops", wrap, 0);

    // Pause at 05 with prescaler 2, hold 50 cycles, resume.
    run(20);
    cycle(1'b1, 1'b0, 1'b0);
    run(50);
    settle();
    chk("paused_ones", ones, 5);
    chk("paused_running", running, 0);
    cycle(1'b1, 1'b0, 1'b0);
    run(1);
    settle();
    chk("resume_plus1_ones", ones, 5);
    run(1);
    settle();
    chk("resume_plus2_ones", ones, 6);

    // Lap freeze at 12, then release.
    run(24);
    cycle(1'b0, 1'b0, 1'b1);
    run(10);
    settle();
    chk("lap_disp_ones", disp_ones, 2);
    chk("lap_disp_tens", disp_tens, 1);
    chk("lap_hold_set", lap_hold, 1);
    cycle(1'b0, 1'b0, 1'b1);
    settle();
    chk("lap_hold_clr", lap_hold, 0);

    // Clear beats start_stop at 37.
    run_until(37);
    cycle(1'b1, 1'b1, 1'b0);
    settle();
    chk("clear_running", running, 0);
    chk("clear_ones", ones, 0);
    chk("clear_tens", tens, 0);
    run(6);

    // Asynchronous reset mid-cycle at 48 with lap held.
    cycle(1'b1, 1'b0, 1'b0);
    run_until(45);
    cycle(1'b0, 1'b0, 1'b1);
    run_until(48);
    settle();
    chk("pre_rst_hold", lap_hold, 1);
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    run(12);

    // Randomized command traffic.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 11) == 0);
    end

    cycle(1'b0, 1'b0, 1'b0);
    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clock cycles per count tick (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start_stop, input, 1, one-cycle command pulse that starts, pauses or resumes counting.
REQ-005 SHALL have port clear, input, 1, one-cycle command pulse that returns to idle and zeroes the count.
REQ-006 SHALL have port lap, input, 1, one-cycle command pulse that toggles the lap-hold display freeze.
REQ-007 SHALL have port ones, output, 4, live BCD units digit (0..9).
REQ-008 SHALL have port tens, output, 4, live BCD tens digit (0..9).
REQ-009 SHALL have port disp_ones, output, 4, displayed units digit (live or frozen).
REQ-010 SHALL have port disp_tens, output, 4, displayed tens digit (live or frozen).
REQ-011 SHALL have port running, output, 1, high while in state RUN.
REQ-012 SHALL have port lap_hold, output, 1, high while the display is frozen.
REQ-013 SHALL have port wrap, output, 1, one-cycle pulse on the 99 -> 00 rollover.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and PAUSE.
REQ-015 SHALL apply these start_stop transitions: IDLE -> RUN, RUN -> PAUSE, PAUSE -> RUN.
REQ-016 SHALL, on clear, move from any state to IDLE with prescaler, ones, tens, lap_hold and wrap all 0 on the next edge.
REQ-017 SHALL give clear priority over start_stop and lap in the same cycle.
REQ-018 SHALL advance the prescaler (0..DIV-1) only in RUN, hold it in PAUSE, and keep it at 0 in IDLE.
REQ-019 SHALL assert the internal tick in a cycle when the state is RUN and the prescaler equals DIV-1; the prescaler then returns to 0.
REQ-020 SHALL, on tick: ones+1; ones 9 -> 0 with carry incrementing tens; at 99, go to 00 and pulse wrap for exactly the following cycle.
REQ-021 SHALL force a digit to 0 on its next increment if it ever holds a value above 9 (no X or illegal BCD propagation).
REQ-022 SHALL use the current state when start_stop coincides with a tick in RUN: the increment occurs, then the state becomes PAUSE.
REQ-023 SHALL, for the first tick after IDLE -> RUN at edge E0, update the count at edge E0+DIV (ones=1).
REQ-024 SHALL honour lap only in RUN or PAUSE; in IDLE it is ignored.
REQ-025 SHALL, on lap with lap_hold=0, capture {tens, ones} into a freeze register and set lap_hold; on lap with lap_hold=1, clear lap_hold.
REQ-026 SHALL drive disp_* combinationally as the freeze register when lap_hold=1, and as ones/tens otherwise.
REQ-027 SHALL, if lap coincides with a tick, capture the pre-increment value.
REQ-028 SHALL derive running combinationally from state == RUN.

Reset
REQ-029 SHALL, on rst low, immediately set: state IDLE; prescaler, ones, tens and freeze register 0; lap_hold 0; wrap 0; running 0.
REQ-030 SHALL, if rst is asserted mid-count, discard all count and lap state; operation resumes only via a new start_stop.

Structure
REQ-031 SHALL place the state encoding (IDLE/RUN/PAUSE) and the BCD max-digit constant (9) in a shared package.
REQ-032 SHALL instantiate sub-module bcd_digit twice, once per digit; each instance has clk, rst, en, clr, a 4-bit q output and a carry output (en && q==9).

Verification
REQ-033 SHALL cover (DIV=4): reset, then start_stop at E0 -> running=1; ones=1 after E4; ones=2 after E8.
REQ-034 SHALL cover: 100 ticks (400 cycles) after start -> ones/tens pass 09 -> 10 at tick 10, reach 99, then 00 with wrap high for exactly one cycle.
REQ-035 SHALL cover: pause at count 05 with prescaler 2, wait 50 cycles, resume -> count still 05 while paused; 06 exactly 2 cycles after resume.
REQ-036 SHALL cover: lap at count 12 while running -> disp=12 and lap_hold=1 while ones/tens continue; second lap -> disp follows live count.
REQ-037 SHALL cover: clear and start_stop in the same cycle during RUN at count 37 -> state IDLE, count 00, running=0.
REQ-038 SHALL cover: rst pulsed low mid-cycle at count 48 with lap_hold=1 -> all outputs 0 immediately, without waiting for a clock edge.
